// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation encodings, FSM states
// and the default datapath width.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [4:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_SLL    = 5'h02,
    OP_SLT    = 5'h03,
    OP_SLTU   = 5'h04,
    OP_XOR    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SRA    = 5'h07,
    OP_OR     = 5'h08,
    OP_AND    = 5'h09,
    OP_PASS   = 5'h0A,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } alu_state_e;

  // 0x10..0x17 are the iterative multiply/divide operations
  function automatic logic is_muldiv(input logic [4:0] opsel);
    return opsel[4] & ~opsel[3];
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply/divide engine: one bit per cycle over operand magnitudes,
// sign correction applied combinationally to the final iteration.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic              active, is_div, neg_res, neg_rem, div0;
  logic [1:0]        fn;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] prod, step, prod_fix;
  logic [XLEN-1:0]   mcand, mag1, mag2, r_new, quo, rem;
  logic [XLEN:0]     sum, r_shift;
  logic              a_s, b_s, a_neg, b_neg, ge;

  always_comb begin
    if (op[2]) begin
      a_s = ~op[0];
      b_s = ~op[0];
    end else begin
      a_s = op[0] ^ op[1];
      b_s = op[0] & ~op[1];
    end
    a_neg = a_s & op1[XLEN-1];
    b_neg = b_s & op2[XLEN-1];
    mag1  = a_neg ? -op1 : op1;
    mag2  = b_neg ? -op2 : op2;
  end

  // prod holds {accumulator, multiplier} for MUL and {remainder, dividend} for DIV
  always_comb begin
    sum     = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mcand} : '0);
    r_shift = prod[2*XLEN-1:XLEN-1];
    ge      = r_shift >= {1'b0, mcand};
    r_new   = ge ? XLEN'(r_shift - {1'b0, mcand}) : r_shift[XLEN-1:0];
    step    = is_div ? {r_new, prod[XLEN-2:0], ge} : {sum, prod[XLEN-1:1]};
  end

  always_comb begin
    prod_fix = neg_res ? -step : step;
    quo      = step[XLEN-1:0];
    rem      = step[2*XLEN-1:XLEN];
    if (is_div) begin
      if (fn[1])     result = neg_rem ? -rem : rem;
      else if (div0) result = '1;
      else           result = neg_res ? -quo : quo;
    end else begin
      result = (fn == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  assign done = active & (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      fn      <= '0;
      cnt     <= '0;
      prod    <= '0;
      mcand   <= '0;
    end else if (start) begin
      active  <= 1'b1;
      is_div  <= op[2];
      fn      <= op[1:0];
      neg_res <= a_neg ^ b_neg;
      neg_rem <= a_neg;
      div0    <= (op2 == '0);
      cnt     <= '0;
      prod    <= {{XLEN{1'b0}}, mag1};
      mcand   <= mag2;
    end else if (active) begin
      if (kill) begin
        active <= 1'b0;
      end else begin
        prod <= step;
        cnt  <= cnt + 1'b1;
        if (done) active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle base ops, iterative multiply/divide, with a
// valid/ready request handshake and registered result.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [4:0]      i_opsel,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_kill,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  alu_state_e      state, state_nxt;
  logic            accept, md_op, md_start, md_done;
  logic [XLEN-1:0] base_res, md_res;

  assign o_ready  = (state == ST_IDLE);
  assign accept   = i_valid & o_ready;
  assign md_op    = is_muldiv(i_opsel);
  assign md_start = accept & md_op;

  always_comb begin
    base_res = '0;
    case (i_opsel)
      OP_ADD:  base_res = i_op1 + i_op2;
      OP_SUB:  base_res = i_op1 - i_op2;
      OP_SLL:  base_res = i_op1 << i_op2[SHW-1:0];
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (i_op1 < i_op2)};
      OP_XOR:  base_res = i_op1 ^ i_op2;
      OP_SRL:  base_res = i_op1 >> i_op2[SHW-1:0];
      OP_SRA:  base_res = $signed(i_op1) >>> i_op2[SHW-1:0];
      OP_OR:   base_res = i_op1 | i_op2;
      OP_AND:  base_res = i_op1 & i_op2;
      OP_PASS: base_res = i_op2;
      default: base_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:        if (md_start) state_nxt = i_opsel[2] ? ST_DIV : ST_MUL;
      ST_MUL, ST_DIV: if (i_kill || md_done) state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .start  (md_start),
    .kill   (i_kill),
    .op     (i_opsel[2:0]),
    .op1    (i_op1),
    .op2    (i_op2),
    .done   (md_done),
    .result (md_res)
  );

  // Kill on the completion cycle suppresses the result
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_zero   <= 1'b1;
    end else if (accept && !md_op) begin
      o_valid  <= 1'b1;
      o_result <= base_res;
      o_zero   <= (base_res == '0);
    end else if (md_done && !i_kill) begin
      o_valid  <= 1'b1;
      o_result <= md_res;
      o_zero   <= (md_res == '0);
    end else begin
      o_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expectations queued at issue, checked on o_valid
// against value, zero flag and arrival cycle.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, i_kill;
  logic [4:0]  i_opsel;
  logic [31:0] i_op1, i_op2;
  logic        o_ready, o_valid, o_zero;
  logic [31:0] o_result;

  typedef struct {
    logic [31:0] res;
    int          due;
    logic [4:0]  op;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          w;
  logic [31:0] last_res = '0;
  logic [4:0]  ops [23] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                            5'h08, 5'h09, 5'h0A, 5'h0B, 5'h1F, 5'h10, 5'h11, 5'h12,
                            5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h0F, 5'h18};

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir [20] = '{
    '{5'h00, 32'h7FFFFFFF, 32'h00000001},
    '{5'h01, 32'h00000005, 32'h00000005},
    '{5'h07, 32'h80000000, 32'd31},
    '{5'h11, 32'h80000000, 32'h80000000},
    '{5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF},
    '{5'h14, 32'h80000000, 32'hFFFFFFFF},
    '{5'h16, 32'h80000000, 32'hFFFFFFFF},
    '{5'h15, 32'd7,        32'd0},
    '{5'h17, 32'd7,        32'd0},
    '{5'h14, 32'hFFFFFFF9, 32'd2},
    '{5'h16, 32'hFFFFFFF9, 32'd2},
    '{5'h10, 32'hFFFFFFFF, 32'd3},
    '{5'h14, 32'hFFFFFFFB, 32'd0},
    '{5'h16, 32'hFFFFFFF9, 32'd0},
    '{5'h12, 32'hFFFFFFFF, 32'd2},
    '{5'h03, 32'hFFFFFFFF, 32'd1},
    '{5'h04, 32'hFFFFFFFF, 32'd1},
    '{5'h02, 32'd1,        32'd33},
    '{5'h0B, 32'h12345678, 32'h1},
    '{5'h0A, 32'h0,        32'hCAFEF00D}
  };

  alu_seq #(.XLEN(XLEN)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_opsel  (i_opsel),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .i_kill   (i_kill),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_zero   (o_zero)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic        ovf;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    model = '0;
    case (op)
      5'h00: model = a + b;
      5'h01: model = a - b;
      5'h02: model = a << b[4:0];
      5'h03: model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'h04: model = (a < b) ? 32'd1 : 32'd0;
      5'h05: model = a ^ b;
      5'h06: model = a >> b[4:0];
      5'h07: model = $signed(a) >>> b[4:0];
      5'h08: model = a | b;
      5'h09: model = a & b;
      5'h0A: model = b;
      5'h10: begin p = {32'b0, a} * {32'b0, b}; model = p[31:0]; end
      5'h11: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); model = p[63:32]; end
      5'h12: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); model = p[63:32]; end
      5'h13: begin p = {32'b0, a} * {32'b0, b}; model = p[63:32]; end
      5'h14: if (b == 0) model = '1; else if (ovf) model = a; else model = $signed(a) / $signed(b);
      5'h15: if (b == 0) model = '1; else model = a / b;
      5'h16: if (b == 0) model = a; else if (ovf) model = '0; else model = $signed(a) % $signed(b);
      5'h17: if (b == 0) model = a; else model = a % b;
      default: model = '0;
    endcase
  endfunction

  always @(negedge i_clk) begin
    exp_t e;
    if (o_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check($sformatf("result_op%02h", e.op), o_result, e.res);
        check($sformatf("zero_op%02h", e.op), o_zero, e.res == 0);
        check($sformatf("latency_op%02h", e.op), cyc, e.due);
        last_res = e.res;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept edge
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit track, output int waited);
    exp_t e;
    waited  = 0;
    i_valid = 1'b1;
    i_opsel = op;
    i_op1   = a;
    i_op2   = b;
    while (!o_ready && waited < 100) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) begin
      check("ready_timeout", 0, 1);
    end else if (track) begin
      e.res = model(op, a, b);
      e.op  = op;
      e.due = cyc + 1 + ((op[4] && !op[3]) ? XLEN : 0);
      sb.push_back(e);
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic [4:0]  op;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_kill  = 1'b0;
    i_opsel = '0;
    i_op1   = '0;
    i_op2   = '0;
    repeat (3) @(negedge i_clk);
    check("rst_valid", o_valid, 0);
    check("rst_result", o_result, 0);
    check("rst_zero", o_zero, 1);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("ready_after_rst", o_ready, 1);

    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, 1'b1, w);
    idle(40);

    issue(OP_DIVU, 32'd100, 32'd7, 1'b1, w);
    issue(OP_ADD, 32'd3, 32'd4, 1'b1, w);
    check("busy_cycles", w, 32);
    idle(3);

    i_kill = 1'b1;
    issue(OP_XOR, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, w);
    i_kill = 1'b0;
    idle(3);

    issue(OP_MUL, 32'd12345, 32'd678, 1'b0, w);
    idle(9);
    i_kill = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0;
    check("ready_after_kill", o_ready, 1);
    check("result_after_kill", o_result, last_res);
    idle(40);
    check("result_hold_kill", o_result, last_res);

    issue(OP_DIV, 32'd1000, 32'd3, 1'b0, w);
    idle(31);
    i_kill = 1'b1;
    @(negedge i_clk);
    i_kill = 1'b0;
    check("ready_kill_at_done", o_ready, 1);
    idle(5);
    check("result_kill_at_done", o_result, last_res);

    issue(OP_DIV, 32'hFFFF0000, 32'd9, 1'b0, w);
    idle(19);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    check("midrst_valid", o_valid, 0);
    check("midrst_result", o_result, 0);
    check("midrst_zero", o_zero, 1);
    i_rst_n = 1'b1;
    last_res = '0;
    @(negedge i_clk);
    check("ready_after_midrst", o_ready, 1);
    idle(40);
    check("result_after_midrst", o_result, 0);

    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 22)];
      case ($urandom_range(0, 5))
        0:       a = 32'h80000000;
        1:       a = '0;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = '1;
        default: b = $urandom;
      endcase
      issue(op, a, b, 1'b1, w);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(1);

    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge i_clk);
    check("drain", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8..64, power of two.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width; derived, not overridden.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 i_valid  input  1  operation request.
REQ-006 o_ready  output  1  block can accept a request this cycle.
REQ-007 i_opsel  input  5  operation select, encodings per REQ-012.
REQ-008 i_op1, i_op2  input  XLEN each  operands, sampled on accept.
REQ-009 i_kill  input  1  abort any in-flight multi-cycle operation.
REQ-010 o_valid  output  1  single-cycle pulse: o_result/o_zero newly updated.
REQ-011 o_result  output  XLEN  registered result; o_zero  output  1  registered (o_result == 0).

Function
REQ-012 Encodings: 0x00 ADD, 0x01 SUB, 0x02 SLL, 0x03 SLT, 0x04 SLTU, 0x05 XOR, 0x06 SRL, 0x07 SRA, 0x08 OR, 0x09 AND, 0x0A PASS op2, 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU, 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU; all others yield result 0 as a base op.
REQ-013 Accept occurs on a rising edge with i_valid=1 and o_ready=1; operands and opsel are captured then.
REQ-014 States: IDLE, MUL, DIV; o_ready = (state == IDLE) or (completion cycle, REQ-018).
REQ-015 Base ops (0x00-0x0A, undefined): computed combinationally, registered at accept edge; o_valid=1 in the following cycle; state stays IDLE; throughput one per cycle.
REQ-016 Shifts use i_op2[SHW-1:0]; SLT/SRA/MULH/DIV treat operands as two's complement; SLTU/SRL unsigned; wrap-around modulo 2^XLEN for ADD/SUB/MUL.
REQ-017 MUL ops: IDLE->MUL; radix-2 shift-add over magnitudes, one bit per cycle, XLEN iterations, then sign correction; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits of the 2*XLEN product.
REQ-018 Completion: o_valid pulses exactly XLEN+1 cycles after accept; state returns to IDLE on that edge; o_ready=1 during the o_valid cycle so a new request can be accepted back-to-back.
REQ-019 DIV ops: IDLE->DIV; restoring division on magnitudes, one quotient bit per cycle, XLEN iterations, sign correction (quotient sign = op1^op2, remainder sign = op1); same latency as REQ-018.
REQ-020 Divide by zero: DIV/DIVU give all-ones, REM/REMU give op1; latency unchanged.
REQ-021 Signed overflow (op1 = most-negative, op2 = -1): DIV gives op1, REM gives 0.
REQ-022 i_kill in MUL/DIV: state -> IDLE next edge, no o_valid, o_result/o_zero unchanged; i_kill in IDLE ignored; i_kill and completion in the same cycle: kill wins.
REQ-023 i_valid while o_ready=0 is ignored (not queued); requester holds it.
REQ-024 o_result and o_zero hold their last value between o_valid pulses.

Reset
REQ-025 While i_rst_n=0: state IDLE, o_valid 0, o_result 0, o_zero 1, iteration counter and working registers 0; o_ready 1 from first edge after deassertion.
REQ-026 Reset mid-operation discards the operation with no o_valid.

Structure
REQ-027 Package alu_pkg holds opsel encoding constants, state enum, and XLEN default.
REQ-028 Iterative multiply/divide datapath is sub-module alu_muldiv_iter (start, kill, op, operands in; done, result out); alu_seq owns handshake, base ops and output registers.

Verification
REQ-029 ADD 0x7FFFFFFF+0x00000001 -> o_valid one cycle after accept, o_result 0x80000000, o_zero 0.
REQ-030 SUB 5-5 then SRA 0x80000000 by 31 back-to-back -> consecutive o_valid, results 0x0 (o_zero 1) then 0xFFFFFFFF.
REQ-031 MULH 0x80000000*0x80000000 -> o_valid 33 cycles after accept, 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
REQ-033 DIVU in flight with ADD held on i_valid -> o_ready 0 for 32 cycles, ADD accepted in completion cycle, its o_valid next cycle.
REQ-034 i_kill at cycle 10 of MUL, and i_rst_n low at cycle 20 of DIV -> no o_valid, o_result unchanged (kill) / 0 (reset), o_ready 1 afterwards.
